// File: rtl/sram_ctrl_if.sv
// Request-side handshake between the frame-buffer logic (master) and the
// SRAM controller (slave): one word per request, ack pulse on completion.
interface sram_ctrl_if #(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 16
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ack;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rdata_valid;
    logic                  busy;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata, rdata_valid, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata, rdata_valid, busy
    );
endinterface

// File: rtl/sram_ctrl.sv
// Async SRAM bus-cycle generator. Each accepted request runs
// IDLE -> SETUP -> STROBE (WAIT_CYCLES clocks) -> HOLD -> IDLE.
// Every SRAM pin and the data-drive enable is a flop output, so strobes
// cannot glitch. The next pin values are decoded from the next state.
module sram_ctrl #(
    parameter int ADDR_WIDTH  = 18,
    parameter int DATA_WIDTH  = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  resetb,
    sram_ctrl_if.slave            bus,
    output logic                  sram_ceb,
    output logic                  sram_web,
    output logic                  sram_oeb,
    inout  wire  [DATA_WIDTH-1:0] sram_data,
    output logic [ADDR_WIDTH-1:0] sram_addr
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  accept_s;
    logic                  strobe_last_s;

    logic                  ceb_q, ceb_d;
    logic                  web_q, web_d;
    logic                  oeb_q, oeb_d;
    logic                  drive_q, drive_d;
    logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
    logic                  ack_q, ack_d;
    logic                  rdata_valid_q, rdata_valid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  busy_q, busy_d;

    // State register plus the request fields captured at acceptance.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            we_q    <= 1'b0;
            wdata_q <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state logic: accept only in IDLE, count strobe clocks down to zero.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        accept_s      = 1'b0;
        strobe_last_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    state_d  = S_SETUP;
                    accept_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                state_d = S_STROBE;
                cnt_d   = CNT_RELOAD;
            end
            S_STROBE: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d       = S_HOLD;
                    strobe_last_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_HOLD: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
        if (accept_s) begin
            we_d    = bus.we;
            wdata_d = bus.wdata;
        end else begin
            we_d    = we_q;
            wdata_d = wdata_q;
        end
    end

    // Output decode: next pin/handshake values derived from the next state.
    always_comb begin
        ceb_d         = 1'b1;
        web_d         = 1'b1;
        oeb_d         = 1'b1;
        drive_d       = 1'b0;
        ack_d         = 1'b0;
        rdata_valid_d = 1'b0;
        busy_d        = (state_d != S_IDLE);
        case (state_d)
            S_IDLE: begin
                ceb_d = 1'b1;
            end
            S_SETUP: begin
                ceb_d = 1'b0;
                if (we_d) begin
                    drive_d = 1'b1;
                end else begin
                    oeb_d = 1'b0;
                end
            end
            S_STROBE: begin
                ceb_d = 1'b0;
                if (we_d) begin
                    web_d   = 1'b0;
                    drive_d = 1'b1;
                end else begin
                    oeb_d = 1'b0;
                end
            end
            S_HOLD: begin
                ack_d = 1'b1;
                if (we_d) begin
                    // Keep chip enabled and data driven while web rises.
                    ceb_d   = 1'b0;
                    drive_d = 1'b1;
                end else begin
                    rdata_valid_d = 1'b1;
                end
            end
            default: begin
                ceb_d = 1'b1;
            end
        endcase
        // Address changes only at acceptance, one clock before web can fall.
        if (accept_s) begin
            sram_addr_d = bus.addr;
        end else begin
            sram_addr_d = sram_addr_q;
        end
        // Read data is taken on the edge that ends the last strobe clock.
        if (strobe_last_s && !we_q) begin
            rdata_d = sram_data;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Output registers: pins, drive enable and handshake all come from flops.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            ceb_q         <= 1'b1;
            web_q         <= 1'b1;
            oeb_q         <= 1'b1;
            drive_q       <= 1'b0;
            sram_addr_q   <= {ADDR_WIDTH{1'b0}};
            ack_q         <= 1'b0;
            rdata_valid_q <= 1'b0;
            rdata_q       <= {DATA_WIDTH{1'b0}};
            busy_q        <= 1'b0;
        end else begin
            ceb_q         <= ceb_d;
            web_q         <= web_d;
            oeb_q         <= oeb_d;
            drive_q       <= drive_d;
            sram_addr_q   <= sram_addr_d;
            ack_q         <= ack_d;
            rdata_valid_q <= rdata_valid_d;
            rdata_q       <= rdata_d;
            busy_q        <= busy_d;
        end
    end

    assign sram_ceb        = ceb_q;
    assign sram_web        = web_q;
    assign sram_oeb        = oeb_q;
    assign sram_addr       = sram_addr_q;
    assign sram_data       = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};
    assign bus.ack         = ack_q;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench: two controllers (1 and 3 wait states), each wired to a
// small behavioural async SRAM that latches on the rising edge of web.
module tb_sram_ctrl;
    localparam int AW = 18;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic resetb;
    bit   clk_en = 1'b0;
    bit   sel = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = clk_en ? ~clk : clk;

    sram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
    sram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();

    logic          ceb1, web1, oeb1, ceb3, web3, oeb3;
    logic [AW-1:0] addr1, addr3;
    wire  [DW-1:0] data1, data3;

    sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .resetb(resetb), .bus(bus1),
        .sram_ceb(ceb1), .sram_web(web1), .sram_oeb(oeb1),
        .sram_data(data1), .sram_addr(addr1)
    );

    sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .resetb(resetb), .bus(bus3),
        .sram_ceb(ceb3), .sram_web(web3), .sram_oeb(oeb3),
        .sram_data(data3), .sram_addr(addr3)
    );

    // Behavioural SRAMs
    logic [DW-1:0] mem1 [0:(1<<AW)-1];
    logic [DW-1:0] mem3 [0:(1<<AW)-1];

    always @(posedge web1) if (!ceb1) mem1[addr1] <= data1;
    always @(posedge web3) if (!ceb3) mem3[addr3] <= data3;

    assign data1 = (!ceb1 && !oeb1) ? mem1[addr1] : {DW{1'bz}};
    assign data3 = (!ceb3 && !oeb3) ? mem3[addr3] : {DW{1'bz}};

    // Views of whichever controller is under test
    wire          ceb_s  = sel ? ceb3 : ceb1;
    wire          web_s  = sel ? web3 : web1;
    wire          oeb_s  = sel ? oeb3 : oeb1;
    wire [AW-1:0] addr_s = sel ? addr3 : addr1;
    wire [DW-1:0] data_s = sel ? data3 : data1;
    wire          ack_s  = sel ? bus3.ack : bus1.ack;
    wire          rv_s   = sel ? bus3.rdata_valid : bus1.rdata_valid;
    wire          busy_s = sel ? bus3.busy : bus1.busy;
    wire [DW-1:0] rd_s   = sel ? bus3.rdata : bus1.rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input bit s, input bit r, input bit w,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (s) begin
            bus3.req = r; bus3.we = w; bus3.addr = a; bus3.wdata = d;
        end else begin
            bus1.req = r; bus1.we = w; bus1.addr = a; bus1.wdata = d;
        end
    endtask

    // One complete access from IDLE, sampled on falling edges; cycle 1 is
    // the clock after the acceptance edge. With toggle set, req and the
    // request fields are scrambled while busy, and req is dropped in HOLD.
    task automatic access(input string p, input bit s, input bit w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW-1:0] exp_rd, input int wc, input bit toggle);
        int n_ceb = 0, n_web = 0, n_oeb = 0, n_busy = 0, n_ack = 0, n_rv = 0;
        int ack_cyc = -1, bad_order = 0, bad_addr = 0, bad_drv = 0;
        sel = s;
        @(negedge clk);
        drive_req(s, 1'b1, w, a, d);
        @(posedge clk);
        for (int c = 1; c <= wc + 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (toggle) drive_req(s, 1'b1, ~w, ~a, ~d);
                else        drive_req(s, 1'b0, w, a, d);
            end else if (toggle && c == wc + 2) begin
                drive_req(s, 1'b0, ~w, ~a, ~d);
            end else begin
                n_ceb = n_ceb;
            end
            if (!ceb_s)  n_ceb++;
            if (!web_s)  n_web++;
            if (!oeb_s)  n_oeb++;
            if (busy_s)  n_busy++;
            if (rv_s)    n_rv++;
            if (ack_s) begin n_ack++; ack_cyc = c; end
            if (!web_s && ceb_s) bad_order++;
            if (!ceb_s && addr_s !== a) bad_addr++;
            if (w && !ceb_s && data_s !== d) bad_drv++;
        end
        check({p, "_ceb_low"},  32'(n_ceb),  w ? 32'(wc + 2) : 32'(wc + 1));
        check({p, "_web_low"},  32'(n_web),  w ? 32'(wc) : 32'd0);
        check({p, "_oeb_low"},  32'(n_oeb),  w ? 32'd0 : 32'(wc + 1));
        check({p, "_busy"},     32'(n_busy), 32'(wc + 2));
        check({p, "_ack_cnt"},  32'(n_ack),  32'd1);
        check({p, "_ack_cyc"},  32'(ack_cyc), 32'(wc + 2));
        check({p, "_rv_cnt"},   32'(n_rv),   w ? 32'd0 : 32'd1);
        check({p, "_web_ceb"},  32'(bad_order), 32'd0);
        check({p, "_addr"},     32'(bad_addr),  32'd0);
        check({p, "_wr_bus"},   32'(bad_drv),   32'd0);
        if (!w) check({p, "_rdata"}, 32'(rd_s), 32'(exp_rd));
    endtask

    initial begin
        logic [10:0] ack_mask;
        logic [10:0] rv_mask;
        resetb = 1'b1;
        drive_req(1'b0, 1'b0, 1'b0, 18'h00000, 16'h0000);
        drive_req(1'b1, 1'b0, 1'b0, 18'h00000, 16'h0000);

        // Reset with the clock stopped
        #1 resetb = 1'b0;
        #2;
        check("rst_ceb",   32'(ceb1), 32'd1);
        check("rst_web",   32'(web1), 32'd1);
        check("rst_oeb",   32'(oeb1), 32'd1);
        check("rst_ack",   32'(bus1.ack), 32'd0);
        check("rst_rv",    32'(bus1.rdata_valid), 32'd0);
        check("rst_busy",  32'(bus1.busy), 32'd0);
        check("rst_rdata", 32'(bus1.rdata), 32'd0);
        check("rst_addr",  32'(addr1), 32'd0);
        check("rst_ceb3",  32'(ceb3), 32'd1);
        #1 clk_en = 1'b1;
        repeat (2) @(negedge clk);
        resetb = 1'b1;

        // One wait state: write then read back; wdata on the read is a decoy
        access("w1_wr", 1'b0, 1'b1, 18'h00005, 16'hA5A5, 16'h0000, 1, 1'b0);
        check("w1_mem", 32'(mem1[5]), 32'h0000A5A5);
        access("w1_rd", 1'b0, 1'b0, 18'h00005, 16'h5A5A, 16'hA5A5, 1, 1'b0);

        // Three wait states, top address, request fields scrambled while busy
        access("w3_wr", 1'b1, 1'b1, 18'h3FFFF, 16'h1234, 16'h0000, 3, 1'b1);
        check("w3_mem", 32'(mem3[18'h3FFFF]), 32'h00001234);
        check("w3_rdata_hold", 32'(bus3.rdata), 32'd0);
        access("w3_rd", 1'b1, 1'b0, 18'h3FFFF, 16'hFFFF, 16'h1234, 3, 1'b1);

        // Back-to-back with req held: write 0x2 then read 0x2
        sel = 1'b0;
        ack_mask = 11'd0;
        rv_mask  = 11'd0;
        @(negedge clk);
        drive_req(1'b0, 1'b1, 1'b1, 18'h00002, 16'hBEEF);
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (ack_s) ack_mask[c] = 1'b1;
            if (rv_s)  rv_mask[c]  = 1'b1;
            if (c == 3)      drive_req(1'b0, 1'b1, 1'b0, 18'h00002, 16'h0000);
            else if (c == 5) drive_req(1'b0, 1'b0, 1'b0, 18'h00002, 16'h0000);
            else             ack_mask[0] = 1'b0;
        end
        check("b2b_ack_mask", 32'(ack_mask), 32'h088);
        check("b2b_rv_mask",  32'(rv_mask),  32'h080);
        check("b2b_rdata",    32'(bus1.rdata), 32'h0000BEEF);
        check("b2b_mem",      32'(mem1[2]),  32'h0000BEEF);

        // Reset in the middle of a write strobe
        sel = 1'b1;
        @(negedge clk);
        drive_req(1'b1, 1'b1, 1'b1, 18'h00100, 16'hCAFE);
        @(posedge clk);
        @(negedge clk);
        drive_req(1'b1, 1'b0, 1'b1, 18'h00100, 16'hCAFE);
        @(negedge clk);
        check("mid_web_low", 32'(web3), 32'd0);
        #1 resetb = 1'b0;
        #1;
        check("mid_ceb",  32'(ceb3), 32'd1);
        check("mid_web",  32'(web3), 32'd1);
        check("mid_oeb",  32'(oeb3), 32'd1);
        check("mid_busy", 32'(bus3.busy), 32'd0);
        check("mid_ack",  32'(bus3.ack), 32'd0);
        @(posedge clk);
        #1;
        check("mid_ack2", 32'(bus3.ack), 32'd0);
        @(negedge clk);
        resetb = 1'b1;
        access("post_wr", 1'b1, 1'b1, 18'h00100, 16'h0F0F, 16'h0000, 3, 1'b0);
        access("post_rd", 1'b1, 1'b0, 18'h00100, 16'h0000, 16'h0F0F, 3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
